// File: rtl/vol_meter_display.sv
// Segmented volume bar with frame-synchronous release and 2-cycle pixel pipe (oled_data follows pixel_index, no stall).
// Optional peak-hold marker is compiled in when PEAK_HOLD_EN is defined.
module vol_meter_display #(
    parameter int SCR_W          = 96,
    parameter int SCR_H          = 64,
    parameter int LEVELS         = 16,
    parameter int LVL_W          = 5,
    parameter int SEG_PITCH      = 3,
    parameter int BAR_X0         = 40,
    parameter int BAR_X1         = 55,
    parameter int BAR_Y_BOT      = 58,
    parameter int RELEASE_FRAMES = 4,
    parameter int HOLD_FRAMES    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             level_valid,
    input  logic [LVL_W-1:0] level_in,
    input  logic [1:0]       bor_sel,
    input  logic [1:0]       theme,
    input  logic [12:0]      pixel_index,
    output logic [15:0]      oled_data
);
    localparam int XW = $clog2(SCR_W + 1);
    localparam int YW = $clog2(8192 / SCR_W + 1);
    localparam int RW = (RELEASE_FRAMES > 1) ? $clog2(RELEASE_FRAMES) : 1;
    localparam logic [LVL_W-1:0] LEV_MAX  = LVL_W'(LEVELS);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [RW-1:0]    REL_LAST = RW'(RELEASE_FRAMES - 1);
    localparam logic [RW-1:0]    REL_ONE  = RW'(1);
    localparam logic [12:0]      W13      = 13'(SCR_W);
    localparam logic [12:0]      NPIX     = 13'(SCR_W * SCR_H);

    if ((1 << LVL_W) <= LEVELS || RELEASE_FRAMES < 1 || HOLD_FRAMES < 1) begin : g_bad_params
        $error("vol_meter_display: inconsistent parameters");
    end

    logic [LVL_W-1:0] clamped;
    logic [LVL_W-1:0] frame_max_q, frame_max_d;
    logic [LVL_W-1:0] disp_q, disp_d;
    logic [RW-1:0]    rel_q, rel_d;

    assign clamped = (level_in > LEV_MAX) ? LEV_MAX : level_in;

    // A sample coinciding with frame_tick belongs to the next frame.
    always_comb begin
        frame_max_d = frame_max_q;
        disp_d      = disp_q;
        rel_d       = rel_q;
        if (frame_tick) begin
            frame_max_d = level_valid ? clamped : '0;
            if (frame_max_q >= disp_q) begin
                disp_d = frame_max_q;
                rel_d  = '0;
            end else if (rel_q == REL_LAST) begin
                disp_d = disp_q - LVL_ONE;
                rel_d  = '0;
            end else begin
                rel_d = rel_q + REL_ONE;
            end
        end else if (level_valid && (clamped > frame_max_q)) begin
            frame_max_d = clamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_max_q <= '0;
            disp_q      <= '0;
            rel_q       <= '0;
        end else begin
            frame_max_q <= frame_max_d;
            disp_q      <= disp_d;
            rel_q       <= rel_d;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [LVL_W-1:0] peak_q, peak_d;
    logic [HW-1:0]    hold_q, hold_d;

    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (frame_tick) begin
            if (disp_d >= peak_q) begin
                peak_d = disp_d;
                hold_d = HOLD_INIT;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_ONE;
            end else begin
                peak_d = ((peak_q - LVL_ONE) > disp_d) ? (peak_q - LVL_ONE) : disp_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end
`endif

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          in_range_q;
    logic [15:0]   pix_d;
    int            xi, yi, bw, d, k;
    logic          border, in_bar, lit;

    function automatic logic [15:0] seg_colour(input int seg, input logic [1:0] th);
        logic [1:0] band;
        band = (seg <= LEVELS / 2) ? 2'd0 : (seg <= (3 * LEVELS) / 4) ? 2'd1 : 2'd2;
        case (th)
            2'd1:    seg_colour = (band == 2'd0) ? 16'h07FF : (band == 2'd1) ? 16'h001F : 16'hF81F;
            2'd2:    seg_colour = 16'hFFFF;
            default: seg_colour = (band == 2'd0) ? 16'h07E0 : (band == 2'd1) ? 16'hFFE0 : 16'hF800;
        endcase
    endfunction

    // d counts rows upward from the bottom of segment 1; the last row of each pitch is the gap.
    always_comb begin
        xi     = int'(x_q);
        yi     = int'(y_q);
        bw     = (bor_sel == 2'd0) ? 0 : (bor_sel == 2'd2) ? 3 : 1;
        d      = BAR_Y_BOT - yi;
        k      = d / SEG_PITCH + 1;
        border = (xi < bw) || (xi >= SCR_W - bw) || (yi < bw) || (yi >= SCR_H - bw);
        in_bar = (xi >= BAR_X0) && (xi <= BAR_X1) && (d >= 0) && (d < LEVELS * SEG_PITCH)
                 && ((d % SEG_PITCH) != SEG_PITCH - 1);
`ifdef PEAK_HOLD_EN
        lit    = (k <= int'(disp_q)) || (k == int'(peak_q));
`else
        lit    = (k <= int'(disp_q));
`endif
        pix_d  = 16'h0000;
        if (!in_range_q) begin
            pix_d = 16'h0000;
        end else if (border) begin
            pix_d = 16'hFFFF;
        end else if (in_bar && lit) begin
            pix_d = seg_colour(k, theme);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            in_range_q <= 1'b0;
            oled_data  <= 16'h0000;
        end else begin
            x_q        <= XW'(pixel_index % W13);
            y_q        <= YW'(pixel_index / W13);
            in_range_q <= (pixel_index < NPIX);
            oled_data  <= pix_d;
        end
    end
endmodule
